// File: rtl/clock_div_gen_pkg.sv
// clock_div_pkg: shared definitions for the clock-enable generator.
//   mode_e        MODE input encodings (2'b11 is reserved and decodes as halt)
//   step_state_e  single-step controller states
//   MIN_DIV       smallest divide ratio a channel will accept
package clock_div_pkg;

   typedef enum logic [1:0] {
      MODE_HALT = 2'b00,
      MODE_RUN  = 2'b01,
      MODE_STEP = 2'b10
   } mode_e;

   typedef enum logic {
      ST_IDLE,
      ST_BUSY
   } step_state_e;

   localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/clock_div_gen_if.sv
// clock_div_gen_if: divide-ratio configuration bus.
//   CFG_WE   write strobe
//   CFG_CH   channel addressed by the write (out-of-range values are ignored)
//   CFG_DIV  new period in CLK cycles (values below MIN_DIV are clamped)
// master drives the bus, slave (the generator) receives it.
interface clock_div_gen_if #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned CNT_W  = 16
);
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic             CFG_WE;
   logic [CH_W-1:0]  CFG_CH;
   logic [CNT_W-1:0] CFG_DIV;

   modport master (output CFG_WE, CFG_CH, CFG_DIV);
   modport slave  (input  CFG_WE, CFG_CH, CFG_DIV);
endinterface

// File: rtl/clock_div_gen_channel.sv
// clock_div_channel: one divider channel.
//   clk_i, rst_ni  system clock, synchronous active-low reset
//   adv_i          counter advances this cycle
//   we_i, div_i    divide-ratio write addressed to this channel
//   clk_out_o      registered square wave, low for div>>1 cycles then high
//   tick_o         registered one-cycle pulse in the cycle after cnt wraps
//   wrap_o         combinational: cnt is at div-1 (wraps if advanced)
module clock_div_channel
   import clock_div_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned DEFAULT_DIV = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             adv_i,
   input  logic             we_i,
   input  logic [CNT_W-1:0] div_i,
   output logic             clk_out_o,
   output logic             tick_o,
   output logic             wrap_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic [CNT_W-1:0] wr_div;
   logic             wrap, load;

   always_comb begin
      cnt_d      = cnt_q;
      div_d      = div_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      wr_div     = (div_i < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : div_i;
      wrap       = (cnt_q == div_q - CNT_W'(1));
      // A ratio may only change at a period boundary: the wrap itself, or a
      // stopped counter sitting at zero.
      load       = adv_i ? wrap : (cnt_q == '0);

      if (adv_i) begin
         cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      end

      // A write coinciding with the load wins over any older pending ratio.
      if (load && we_i) begin
         div_d      = wr_div;
         pend_vld_d = 1'b0;
      end else if (load && pend_vld_q) begin
         div_d      = pend_q;
         pend_vld_d = 1'b0;
      end else if (we_i) begin
         pend_d     = wr_div;
         pend_vld_d = 1'b1;
      end

      tick_d    = adv_i && wrap;
      // Computed from next-state values so the flop matches cnt with no lag.
      clk_out_d = (cnt_d >= (div_d >> 1));
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q      <= '0;
         div_q      <= CNT_W'(DEFAULT_DIV);
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         clk_out_q  <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         clk_out_q  <= clk_out_d;
         tick_q     <= tick_d;
      end
   end

   assign clk_out_o = clk_out_q;
   assign tick_o    = tick_q;
   assign wrap_o    = wrap;

endmodule

// File: rtl/clock_div_gen.sv
// clock_div_gen: multi-channel clock-enable generator.
//   CLK, RST_N   system clock, synchronous active-low reset
//   MODE         00 halt, 01 run, 10 single-step, 11 halt
//   STEP_REQ     level request for one channel-0 period in step mode
//   cfg          divide-ratio configuration bus (slave side)
//   CLK_OUT      per-channel divided square wave
//   TICK         per-channel one-cycle enable at each period start
//   STEP_BUSY    a single step is in progress
module clock_div_gen
   import clock_div_pkg::*;
#(
   parameter  int unsigned NUM_CH      = 2,
   parameter  int unsigned CNT_W       = 16,
   parameter  int unsigned DEFAULT_DIV = 2,
   localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [1:0]        MODE,
   input  logic              STEP_REQ,
   clock_div_gen_if.slave    cfg,
   output logic [NUM_CH-1:0] CLK_OUT,
   output logic [NUM_CH-1:0] TICK,
   output logic              STEP_BUSY
);

   step_state_e       state_q, state_d;
   logic              is_run, is_step, adv;
   logic [CH_W-1:0]   ch_sel;
   logic              ch_valid;
   logic [NUM_CH-1:0] wrap;
   logic              unused_wrap;

   always_comb begin
      is_run      = (MODE == MODE_RUN);
      is_step     = (MODE == MODE_STEP);
      // Leaving step mode mid-step freezes the counters in that same cycle.
      adv         = is_run || (state_q == ST_BUSY && is_step);
      ch_sel      = cfg.CFG_CH;
      ch_valid    = cfg.CFG_WE && (32'(ch_sel) < NUM_CH);
      unused_wrap = ^wrap;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (is_step && STEP_REQ) state_d = ST_BUSY;
         ST_BUSY: if (!is_step || wrap[0]) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   assign STEP_BUSY = (state_q == ST_BUSY);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clock_div_channel #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_i     (CLK),
         .rst_ni    (RST_N),
         .adv_i     (adv),
         .we_i      (ch_valid && (32'(ch_sel) == 32'(i))),
         .div_i     (cfg.CFG_DIV),
         .clk_out_o (CLK_OUT[i]),
         .tick_o    (TICK[i]),
         .wrap_o    (wrap[i])
      );
   end

endmodule

// File: tb/tb_clock_div_gen.sv
module tb_clock_div_gen;
   import clock_div_pkg::*;

   localparam int NCH = 2;
   localparam int DEF = 2;

   logic           CLK;
   logic           RST_N;
   logic [1:0]     MODE;
   logic           STEP_REQ;
   logic [NCH-1:0] CLK_OUT;
   logic [NCH-1:0] TICK;
   logic           STEP_BUSY;

   clock_div_gen_if #(.NUM_CH(NCH), .CNT_W(16)) cif ();

   clock_div_gen #(
      .NUM_CH      (NCH),
      .CNT_W       (16),
      .DEFAULT_DIV (DEF)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .MODE      (MODE),
      .STEP_REQ  (STEP_REQ),
      .cfg       (cif),
      .CLK_OUT   (CLK_OUT),
      .TICK      (TICK),
      .STEP_BUSY (STEP_BUSY)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int checks = 0;
   int bad    = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: per channel a period counter modulo the ratio, the
   // active ratio and an optional pending ratio; plus the step-busy flag.
   int m_cnt [NCH];
   int m_div [NCH];
   int m_pend[NCH];
   bit m_pvld[NCH];
   bit m_tick[NCH];
   bit m_busy;
   bit m_ok;
   bit mr_run, mr_stp, mr_go, mr_end0, mr_end, mr_wr, mr_edge;
   int mr_nd;

   initial begin
      m_ok = 1'b0;
      forever begin
         @(posedge CLK);
         if (!RST_N) begin
            for (int i = 0; i < NCH; i++) begin
               m_cnt[i] = 0; m_div[i] = DEF; m_pend[i] = 0;
               m_pvld[i] = 1'b0; m_tick[i] = 1'b0;
            end
            m_busy = 1'b0;
            m_ok   = 1'b1;
         end else begin
            mr_run  = (MODE == 2'b01);
            mr_stp  = (MODE == 2'b10);
            mr_go   = mr_run || (m_busy && mr_stp);
            mr_end0 = mr_go && (m_cnt[0] == m_div[0] - 1);
            mr_nd   = (int'(cif.CFG_DIV) < 2) ? 2 : int'(cif.CFG_DIV);
            for (int i = 0; i < NCH; i++) begin
               mr_end  = mr_go && (m_cnt[i] == m_div[i] - 1);
               mr_wr   = cif.CFG_WE && (int'(cif.CFG_CH) == i);
               mr_edge = mr_end || (!mr_go && m_cnt[i] == 0);
               if (mr_go) m_cnt[i] = (m_cnt[i] + 1) % m_div[i];
               m_tick[i] = mr_end;
               if (mr_edge && mr_wr) begin
                  m_div[i] = mr_nd; m_pvld[i] = 1'b0;
               end else if (mr_edge && m_pvld[i]) begin
                  m_div[i] = m_pend[i]; m_pvld[i] = 1'b0;
               end else if (mr_wr) begin
                  m_pend[i] = mr_nd; m_pvld[i] = 1'b1;
               end
            end
            if (!mr_stp)      m_busy = 1'b0;
            else if (!m_busy) m_busy = STEP_REQ;
            else              m_busy = !mr_end0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge CLK);
         if (m_ok) begin
            for (int i = 0; i < NCH; i++) begin
               chk($sformatf("model_clk_out[%0d]", i), int'(CLK_OUT[i]),
                   (m_cnt[i] >= m_div[i] / 2) ? 1 : 0);
               chk($sformatf("model_tick[%0d]", i), int'(TICK[i]), int'(m_tick[i]));
            end
            chk("model_step_busy", int'(STEP_BUSY), int'(m_busy));
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic cfg_write(input int ch, input int dv);
      cif.CFG_WE  = 1'b1;
      cif.CFG_CH  = 1'(ch);
      cif.CFG_DIV = 16'(dv);
      cyc(1);
      cif.CFG_WE  = 1'b0;
   endtask

   task automatic do_reset();
      MODE  = 2'b00;
      RST_N = 1'b0;
      cyc(1);
      RST_N = 1'b1;
   endtask

   int n_t0, n_t1, n_h0, n_h1;

   initial begin
      RST_N = 1'b0; MODE = 2'b00; STEP_REQ = 1'b0;
      cif.CFG_WE = 1'b0; cif.CFG_CH = '0; cif.CFG_DIV = '0;
      cyc(2);
      chk("reset_clk_out", int'(CLK_OUT), 0);
      chk("reset_tick", int'(TICK), 0);
      chk("reset_busy", int'(STEP_BUSY), 0);
      RST_N = 1'b1;

      // ch0 div=4 in RUN: CLK_OUT 0,0,1,1 by cnt, TICK at cycles 4,8,12.
      cfg_write(0, 4);
      MODE = 2'b01;
      for (int k = 1; k <= 12; k++) begin
         cyc(1);
         chk($sformatf("run4_tick_c%0d", k), int'(TICK[0]), (k % 4 == 0) ? 1 : 0);
         chk($sformatf("run4_clk_c%0d", k), int'(CLK_OUT[0]), ((k % 4) >= 2) ? 1 : 0);
      end

      // ch1 div=5, ch0 div=0 (clamped to 2); measure a 10-cycle window.
      cfg_write(1, 5);
      cfg_write(0, 0);
      cyc(12);
      n_t0 = 0; n_t1 = 0; n_h0 = 0; n_h1 = 0;
      for (int k = 0; k < 10; k++) begin
         cyc(1);
         n_t0 += int'(TICK[0]);    n_t1 += int'(TICK[1]);
         n_h0 += int'(CLK_OUT[0]); n_h1 += int'(CLK_OUT[1]);
      end
      chk("div5_ticks", n_t1, 2);
      chk("div5_high", n_h1, 6);
      chk("div0clamp_ticks", n_t0, 5);
      chk("div0clamp_high", n_h0, 5);

      // div=8 written while cnt=1 at div=4: one more 4-period, then 8.
      do_reset();
      cfg_write(0, 4);
      MODE = 2'b01;
      cyc(1);
      cfg_write(0, 8);
      for (int j = 1; j <= 18; j++) begin
         cyc(1);
         chk($sformatf("retarget_tick_j%0d", j), int'(TICK[0]),
             (j == 2 || j == 10 || j == 18) ? 1 : 0);
      end

      // Single step with div0=4; a second request while busy is ignored.
      do_reset();
      cfg_write(0, 4);
      MODE = 2'b10;
      cyc(2);
      chk("step_idle_busy", int'(STEP_BUSY), 0);
      STEP_REQ = 1'b1;
      cyc(1);
      STEP_REQ = 1'b0;
      chk("step_busy_set", int'(STEP_BUSY), 1);
      for (int j = 1; j <= 8; j++) begin
         if (j == 2) STEP_REQ = 1'b1;
         cyc(1);
         if (j == 2) STEP_REQ = 1'b0;
         chk($sformatf("step_busy_j%0d", j), int'(STEP_BUSY), (j <= 3) ? 1 : 0);
         chk($sformatf("step_tick_j%0d", j), int'(TICK[0]), (j == 4) ? 1 : 0);
         if (j >= 5) chk($sformatf("step_frozen_j%0d", j), int'(CLK_OUT[0]), 0);
      end

      // RUN to cnt=2, HALT 10 cycles, resume: tick 2 cycles later.
      MODE = 2'b01;
      cyc(2);
      MODE = 2'b00;
      for (int j = 1; j <= 10; j++) begin
         cyc(1);
         chk($sformatf("halt_tick_j%0d", j), int'(TICK[0]), 0);
         chk($sformatf("halt_clk_j%0d", j), int'(CLK_OUT[0]), 1);
      end
      MODE = 2'b01;
      cyc(1);
      chk("resume_tick_1", int'(TICK[0]), 0);
      cyc(1);
      chk("resume_tick_2", int'(TICK[0]), 1);

      // Reset in the middle of a step with div0=6.
      MODE = 2'b00;
      cfg_write(0, 6);
      MODE = 2'b10;
      STEP_REQ = 1'b1;
      cyc(1);
      STEP_REQ = 1'b0;
      cyc(2);
      chk("midstep_busy", int'(STEP_BUSY), 1);
      RST_N = 1'b0;
      cyc(1);
      chk("midstep_rst_clk_out", int'(CLK_OUT), 0);
      chk("midstep_rst_tick", int'(TICK), 0);
      chk("midstep_rst_busy", int'(STEP_BUSY), 0);
      RST_N = 1'b1;
      MODE  = 2'b01;
      cyc(1);
      chk("postrst_tick_1", int'(TICK[0]), 0);
      cyc(1);
      chk("postrst_tick_2", int'(TICK[0]), 1);

      cyc(2);
      $display("test done: total=%0d bad=%0d", checks, bad);
      $finish;
   end

endmodule

// File: doc/clock_div_gen.md
# clock_div_gen

Parametrised multi-channel clock-enable generator that supersedes the single free-running `clock` source in the datapath. Each channel produces a divided square wave and a one-cycle tick enable from the one system clock, with a programmable divide ratio. A global mode selects halt, free-run or single-step, so the processor can be stepped one slow-clock period at a time during bring-up. Downstream logic uses `TICK` as a clock enable and `CLK_OUT` only for observation or LEDs.

## Interface
- `NUM_CH`, 2: number of independent channels (≥1).
- `CNT_W`, 16: counter and divide-ratio width.
- `DEFAULT_DIV`, 2: divide ratio loaded into every channel at reset (≥2).
- `CH_W`, derived, max(1, $clog2(NUM_CH)): channel-select width.

- `CLK`  in  1  sole system clock; all logic on rising edge.
- `RST_N`  in  1  reset, synchronous and active-low.
- `MODE`  in  2  00 HALT, 01 RUN, 10 STEP, 11 reserved (behaves as HALT).
- `STEP_REQ`  in  1  request one period in STEP mode; level sampled each cycle.
- `CFG_WE`  in  1  divide-ratio write strobe.
- `CFG_CH`  in  CH_W  channel addressed by the write; values ≥NUM_CH are ignored.
- `CFG_DIV`  in  CNT_W  new period in `CLK` cycles.
- `CLK_OUT`  out  NUM_CH  divided square wave per channel.
- `TICK`  out  NUM_CH  one-cycle enable per channel period.
- `STEP_BUSY`  out  1  a step is in progress.

## Operation
- Per channel: `cnt` counts 0..div-1 and wraps to 0. `div` is the active ratio; `pend` is a shadow ratio with a valid flag.
- Advance condition: MODE=RUN, or STEP_BUSY=1. In HALT, reserved mode, or STEP while idle, `cnt`, `CLK_OUT` and `pend` are frozen and `TICK`=0.
- `CLK_OUT[i]` = (cnt ≥ div>>1), held in a flop that tracks `cnt` with zero skew.
  - Low for div>>1 cycles, then high for div−(div>>1) cycles.
  - Odd ratios give the longer half high.
- `TICK[i]` is high for exactly one cycle: the cycle in which `cnt` has just wrapped from div−1 to 0.
- Config write, CFG_WE=1 with a valid `CFG_CH`:
  - `pend` ← max(CFG_DIV, 2) and the flag is set.
  - `pend` loads into `div` on the next wrap to 0, or at once if the channel is not advancing and cnt=0.
  - A second write before the load overwrites `pend`.
- STEP mode:
  - STEP_REQ=1 while STEP_BUSY=0 sets STEP_BUSY on the next cycle.
  - All channels advance until channel 0 wraps. STEP_BUSY clears in the same cycle that `TICK[0]` pulses.
  - STEP_REQ while busy is ignored.
  - A held STEP_REQ re-arms on the cycle after STEP_BUSY clears.
- Changing MODE away from STEP mid-step clears STEP_BUSY and freezes the counters where they are. RUN→HALT freezes mid-period; HALT→RUN resumes from the frozen `cnt`.
- Reset: cnt=0, div=DEFAULT_DIV, pend flag=0, CLK_OUT=0, TICK=0, STEP_BUSY=0. Reset mid-step or mid-write discards that state.

## Timing
- Latency from MODE=RUN to the first `cnt` increment: 1 cycle. First TICK after reset in RUN: cycle DEFAULT_DIV.
- STEP_REQ to STEP_BUSY=1: 1 cycle. STEP_BUSY stays high for div0 cycles, counted from the step's first increment.
- Config write to effect: at the wrap following the write. The `TICK` on that wrap still belongs to the old period.
- Simultaneous CFG_WE and wrap on the same channel: the new ratio applies from that wrap, i.e. the next period.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `clock_div_pkg`:
  - MODE encodings `MODE_HALT`, `MODE_RUN`, `MODE_STEP`.
  - `MIN_DIV`=2.
- Sub-module `clock_div_channel`, instantiated NUM_CH times. It holds `cnt`, `div`, `pend`, the `CLK_OUT` flop and the `TICK` logic, and takes an `adv` input.
- Top level holds mode decode, the step FSM (IDLE, BUSY) and config address decode.

## Test plan
- Reset, RUN, ch0 div=4: CLK_OUT[0] reads 0,0,1,1 repeating; TICK[0] is high on cycles 4, 8, 12.
- Write ch1 div=5, then write div=0 to ch0: ch1 is low 2 / high 3 after its next wrap; ch0 clamps to 2 and alternates every cycle.
- Write ch0 div=8 while cnt=1 at div=4: exactly one more 4-cycle period completes, then 8-cycle periods follow.
- STEP mode, div0=4, STEP_REQ pulse: STEP_BUSY is high for 4 cycles, exactly one TICK[0], counters frozen afterwards; a second STEP_REQ during busy produces no extra tick.
- RUN→HALT at cnt=2 for 10 cycles, then RUN: outputs hold during HALT and the next TICK arrives 2 cycles after resume.
- RST_N low for 1 cycle mid-step with div0=6: next cycle all outputs are 0, div=DEFAULT_DIV and STEP_BUSY=0.
